// File: rtl/conv_pkg.sv
// Shared definitions for the conv_8 layer family.
// Holds the fixed datapath widths of the conv_8 multiplier chain, the scalar
// types built on them, and a helper that gives the minimum accumulator width
// that cannot overflow for a given window size.
package conv_pkg;

  localparam int PROD_W    = 24;
  localparam int OUT_W     = 16;
  localparam int ACC_W_DEF = 34;

  typedef logic signed [PROD_W-1:0]    prod_t;
  typedef logic signed [OUT_W-1:0]     act_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  // Bias (OUT_W bits) plus num_taps products of prod_w bits: one growth bit per
  // doubling of the tap count, plus one for the bias term.
  function automatic int acc_w_min(input int num_taps, input int prod_w);
    return prod_w + $clog2(num_taps) + 1;
  endfunction

endpackage

// File: rtl/conv_8_requant.sv
// Combinational requantiser: round-half-up, arithmetic right shift, optional
// ReLU, then saturation to a signed OUT_W activation.
// Ports:
//   sum - signed ACC_W accumulated window sum
//   res - signed OUT_W saturated result
module conv_8_requant #(
  parameter int ACC_W = 34,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16,
  parameter int RELU  = 0
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] res
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;
  logic signed [EXT_W-1:0] clamped;

  always_comb begin
    sum_ext = {sum[ACC_W-1], sum};
    biased  = sum_ext + HALF;
    shifted = biased >>> SHIFT;
    clamped = shifted;
    if (RELU != 0 && shifted[EXT_W-1]) begin
      clamped = '0;
    end
    if (clamped > MAX_V) begin
      res = MAX_V[OUT_W-1:0];
    end else if (clamped < MIN_V) begin
      res = MIN_V[OUT_W-1:0];
    end else begin
      res = clamped[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_8_acc_requant.sv
// Window accumulator and requantiser behind the conv_8 multiplier.
// Sums NUM_TAPS signed products per output pixel (seeded with bias on tap 0),
// requantises the final sum and holds it in a one-entry valid/ready register.
// Ports:
//   ap_clk, ap_rst_n            - clock, async active-low reset
//   clear                       - synchronous abort of the partial window
//   in_valid/in_ready/in_data   - product stream
//   bias                        - per-channel bias, sampled with tap 0
//   out_valid/out_ready/out_data- result stream
//   busy                        - a window is partially accumulated
module conv_8_acc_requant #(
  parameter int NUM_TAPS = 9,
  parameter int PROD_W   = 24,
  parameter int ACC_W    = 34,
  parameter int SHIFT    = 8,
  parameter int OUT_W    = 16,
  parameter int RELU     = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic signed [OUT_W-1:0]  bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);

  import conv_pkg::*;

  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  logic [CNT_W-1:0]         tap_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [OUT_W-1:0]  res_next;
  logic                     first_tap;
  logic                     last_tap;
  logic                     take;

  assign first_tap = (tap_cnt == '0);
  assign last_tap  = (tap_cnt == LAST_TAP);

  // Only the last tap needs room in the output register; a transfer in the
  // same cycle frees it, so out_ready feeds in_ready combinationally.
  assign in_ready = !clear && (!last_tap || !out_valid || out_ready);
  assign take     = in_valid && in_ready;
  assign busy     = !first_tap;

  assign prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
  assign bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
  assign sum_next = (first_tap ? bias_ext : acc) + prod_ext;

  conv_8_requant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .RELU  (RELU)
  ) u_requant (
    .sum (sum_next),
    .res (res_next)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tap_cnt <= '0;
      acc     <= '0;
    end else if (clear) begin
      tap_cnt <= '0;
      acc     <= '0;
    end else if (take) begin
      if (last_tap) begin
        // Finished sum goes straight to the output register.
        tap_cnt <= '0;
      end else begin
        tap_cnt <= tap_cnt + CNT_W'(1);
        acc     <= sum_next;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (take && last_tap) begin
      out_valid <= 1'b1;
      out_data  <= res_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_8_acc_requant.sv
module tb_conv_8_acc_requant;
  import conv_pkg::*;

  localparam int NT = 9;
  localparam int SH = 8;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  clear = 1'b0;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  prod_t in_data = '0;
  act_t  bias = '0;

  logic  ir0, ov0, busy0, ir1, ov1, busy1;
  act_t  od0, od1;

  int total = 0;
  int bad = 0;

  // reference model state
  int     m_taps = 0;
  longint m_acc = 0;
  bit     m_pv = 0;
  longint m_pd0 = 0;
  longint m_pd1 = 0;
  int     m_xfer = 0;
  int     d_xfer = 0;
  bit     last_take = 0;

  always #5 clk = ~clk;

  conv_8_acc_requant #(.NUM_TAPS(NT), .SHIFT(SH), .RELU(0)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(ir0), .in_data(in_data), .bias(bias), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .busy(busy0)
  );

  conv_8_acc_requant #(.NUM_TAPS(NT), .SHIFT(SH), .RELU(1)) dut_relu (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(ir1), .in_data(in_data), .bias(bias), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .busy(busy1)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // floor((s + 2^(SH-1)) / 2^SH), optional ReLU, saturate to 16 bits
  function automatic longint rq(input longint s, input bit relu);
    longint t, q, d;
    d = longint'(1) << SH;
    t = s + d / 2;
    q = t / d;
    if (t < 0 && (t % d) != 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic model_reset();
    m_taps = 0; m_acc = 0; m_pv = 0; m_pd0 = 0; m_pd1 = 0;
  endtask

  // One clock: check outputs on the falling edge, advance the model on the
  // rising edge, return 1 time unit after it.
  task automatic cycle();
    bit rdy, take, xfer;
    longint s;
    @(negedge clk);
    rdy = !clear && (m_taps < NT - 1 || !m_pv || out_ready);
    chk("in_ready", longint'(ir0), longint'(rdy));
    chk("in_ready_relu", longint'(ir1), longint'(rdy));
    chk("out_valid", longint'(ov0), longint'(m_pv));
    chk("out_valid_relu", longint'(ov1), longint'(m_pv));
    chk("out_data", longint'(od0), m_pd0);
    chk("out_data_relu", longint'(od1), m_pd1);
    chk("busy", longint'(busy0), longint'(m_taps != 0));
    chk("busy_relu", longint'(busy1), longint'(m_taps != 0));
    if (ov0 && out_ready) d_xfer++;
    take = in_valid && rdy;
    xfer = m_pv && out_ready;
    @(posedge clk);
    last_take = 0;
    if (rst_n) begin
      last_take = take;
      if (xfer) begin m_pv = 0; m_xfer++; end
      if (clear) begin
        m_taps = 0; m_acc = 0;
      end else if (take) begin
        s = (m_taps == 0 ? longint'(bias) : m_acc) + longint'(in_data);
        if (m_taps == NT - 1) begin
          m_pd0 = rq(s, 0); m_pd1 = rq(s, 1); m_pv = 1; m_taps = 0;
        end else begin
          m_acc = s; m_taps++;
        end
      end
    end
    #1;
  endtask

  task automatic send_tap(input longint v, input longint b);
    int n;
    n = 0;
    in_valid = 1; in_data = prod_t'(v); bias = act_t'(b);
    do begin cycle(); n++; end while (!last_take && n < 40);
    if (!last_take) chk("tap_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic send_window(input longint b, input longint first, input longint rest);
    send_tap(first, b);
    for (int i = 1; i < NT; i++) send_tap(rest, -1234);
  endtask

  task automatic drain();
    out_ready = 1; in_valid = 0; cycle();
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", longint'(ov0), 0);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_out_data", longint'(od0), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // 1. basic window
    out_ready = 1;
    send_window(0, 256, 256);
    chk("basic_valid", longint'(ov0), 1);
    chk("basic_data", longint'(od0), 9);
    cycle();
    chk("basic_single_pulse", longint'(ov0), 0);
    chk("basic_hold", longint'(od0), 9);

    // 2. rounding
    send_window(0, 384, 0);
    chk("round_pos", longint'(od0), 2);
    send_window(0, -384, 0);
    chk("round_neg", longint'(od0), -1);
    send_window(100, -25700, 0);
    chk("round_bias", longint'(od0), -100);
    chk("round_bias_relu", longint'(od1), 0);
    drain();

    // 3. saturation, both ReLU settings
    send_window(0, 8388607, 8388607);
    chk("sat_pos", longint'(od0), 32767);
    chk("sat_pos_relu", longint'(od1), 32767);
    send_window(0, -8388608, -8388608);
    chk("sat_neg", longint'(od0), -32768);
    chk("sat_neg_relu", longint'(od1), 0);
    drain();

    // 4. backpressure
    out_ready = 0;
    send_window(0, 256, 256);
    chk("bp_first", longint'(od0), 9);
    for (int i = 0; i < NT - 1; i++) send_tap(512, 7);
    in_valid = 1; in_data = prod_t'(512);
    #1;
    chk("bp_stall_ready", longint'(ir0), 0);
    cycle(); cycle();
    chk("bp_hold_data", longint'(od0), 9);
    chk("bp_hold_valid", longint'(ov0), 1);
    out_ready = 1;
    cycle();
    chk("bp_tap_taken", longint'(last_take), 1);
    in_valid = 0; out_ready = 0;
    chk("bp_second_valid", longint'(ov0), 1);
    chk("bp_second_data", longint'(od0), 18);
    cycle();
    drain();
    chk("bp_drained", longint'(ov0), 0);

    // 5. clear mid-window
    for (int i = 0; i < 4; i++) send_tap(1000, 55);
    clear = 1; in_valid = 1; in_data = prod_t'(1000);
    #1;
    chk("clear_ready", longint'(ir0), 0);
    cycle();
    clear = 0; in_valid = 0;
    chk("clear_busy", longint'(busy0), 0);
    send_window(0, 256, 256);
    chk("clear_after", longint'(od0), 9);
    drain();

    // 6. async reset mid-window and with a held result
    for (int i = 0; i < 3; i++) send_tap(5000, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", longint'(busy0), 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    out_ready = 0;
    send_window(0, 256, 256);
    chk("arst_pre_valid", longint'(ov0), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", longint'(ov0), 0);
    chk("arst_data", longint'(od0), 0);
    chk("arst_busy2", longint'(busy0), 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    send_window(0, 512, 512);
    chk("arst_after", longint'(od0), 18);
    drain();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clear     = ($urandom % 60) == 0;
      bias      = act_t'($urandom);
      case ($urandom % 3)
        0: in_data = prod_t'($urandom);
        1: in_data = prod_t'($signed($urandom_range(0, 4000)) - 2000);
        default: in_data = ($urandom % 2) ? prod_t'(24'h7fffff) : prod_t'(24'h800000);
      endcase
      cycle();
    end
    in_valid = 0; clear = 0; out_ready = 1;
    cycle(); cycle();
    chk("xfer_count", longint'(d_xfer), longint'(m_xfer));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_8_acc_requant.md
Name: conv_8_acc_requant

Overview:
- Downstream stage of the conv_8 16x8 signed multiplier; consumes its 24-bit signed products one per cycle.
- Accumulates NUM_TAPS products per output pixel, seeded with a per-channel bias.
- Rounds, arithmetic-shifts, optionally applies ReLU, and saturates to a 16-bit activation.
- Presents the result on a one-entry valid/ready output register to the next layer stage.

Parameters:
- NUM_TAPS, 9: products per output (kernel window size); legal range 2..256.
- PROD_W, 24: product input width, signed; matches multiplier output.
- ACC_W, 34: accumulator width; must be >= PROD_W + clog2(NUM_TAPS) + 1.
- SHIFT, 8: right-shift applied before saturation; legal range 1..ACC_W-16.
- OUT_W, 16: output width, signed.
- RELU, 0: 1 clamps negative results to 0 after shift, before saturation.

Ports:
- ap_clk, in, 1: clock; all state changes on the rising edge.
- ap_rst_n, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous abort of the partial window.
- in_valid, in, 1: product valid.
- in_ready, out, 1: stage can accept a product.
- in_data, in, PROD_W: signed product.
- bias, in, OUT_W: signed bias; sampled with tap 0 of each window.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, OUT_W: signed saturated result.
- busy, out, 1: tap_cnt != 0, meaning a window is partially accumulated.

Behaviour:
- Reset (async assert, sync release)
  - tap_cnt=0, acc=0, out_valid=0, out_data=0, busy=0.
  - Reset mid-window discards the partial sum and any held result.
- Handshakes
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- in_ready
  - Low when clear=1.
  - Otherwise 1 for taps 0..NUM_TAPS-2.
  - For the last tap: in_ready = !out_valid || out_ready.
  - No combinational path from in_valid to in_ready.
- Accumulation
  - Tap 0: acc <= sext(bias) + sext(in_data).
  - Later taps: acc <= acc + sext(in_data).
  - tap_cnt increments per accepted product.
  - Last tap: tap_cnt wraps to 0; the finished sum goes straight to requant, not back into acc.
- Requant (combinational on the final sum, registered into out_data)
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT: round-half-up, arithmetic shift.
  - If RELU=1 and r<0, r = 0.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency and throughput
  - out_valid rises the cycle after the last tap is accepted.
  - Sustained throughput is 1 product/cycle; windows are back-to-back with no bubble.
- Output register
  - out_data is held stable while out_valid && !out_ready.
  - Transfer plus a new last tap in the same cycle: out_data reloads and out_valid stays 1.
  - Transfer with no new result: out_valid <= 0 and out_data holds its last value.
- clear
  - tap_cnt <= 0; the partial acc is dropped and the in_data of that cycle is not accepted.
  - out_valid and out_data are unaffected; a pending result still drains.
- Bias is ignored on taps other than tap 0.
- States are implicit in tap_cnt: IDLE (0, !busy), ACCUM (1..NUM_TAPS-1), plus the orthogonal out_valid flag.

Decomposition:
- Shared package conv_pkg holds:
  - PROD_W and OUT_W constants.
  - Typedefs prod_t (signed PROD_W), act_t (signed OUT_W), acc_t.
  - A clog2-based ACC_W helper function.
- One sub-module, conv_8_requant: purely combinational round, shift, ReLU and saturate.
  - Parameterised by ACC_W, SHIFT, OUT_W, RELU.
  - Reused by other conv layers.
- The top holds the counter, accumulator, handshake and output register.

Test Plan:
1. Basic window: NUM_TAPS=9, SHIFT=8, bias=0, nine products of 256 back-to-back -> exactly one out_valid pulse, one cycle after tap 9, out_data=9.
2. Rounding: bias=0, tap0=384, rest 0 -> out_data=2. Then tap0=-384, rest 0 -> out_data=-1. Then bias=100, tap0=-25700, rest 0 -> out_data=-100.
3. Saturation:
   - Nine products of 8388607 -> 32767.
   - Nine of -8388608 -> -32768.
   - With RELU=1 the negative case gives 0, and the positive case still gives 32767.
4. Backpressure:
   - Stimulus: out_ready=0, two windows streamed (first: products 256 -> 9; second: products 512 -> 18).
   - in_ready drops only at the second window's tap 9; out_data holds 9.
   - Raise out_ready one cycle: 9 transfers, tap 9 is accepted in the same cycle, the next cycle shows 18 with out_valid kept high.
   - No result lost or duplicated.
5. clear mid-window: 4 taps of 1000, then clear=1 with in_valid=1 -> product not accepted, busy=0. Next full window (products 256, bias 0) -> 9, uncorrupted.
6. Async reset: assert ap_rst_n=0 mid-window and again while out_valid=1 with out_ready=0 -> out_valid, out_data, busy go 0 without waiting for a clock edge. The first post-reset window yields its correct value.
